// File: rtl/sha_256_stream.sv
// SHA-256 / SHA-224 streaming hash core.
// Accepts one pre-padded 512-bit block per handshake and chains blocks into a message.
// Computes ROUNDS_PER_CYCLE compression rounds per clock.
// Presents the digest with a valid/ready handshake once the last block of a message is done.
module sha_256_stream #(
    parameter int MODE             = 0,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         blk_valid,
    output logic         blk_ready,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rounds
        $error("sha_256_stream: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("sha_256_stream: MODE must be 0 (SHA-256) or 1 (SHA-224)");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        UPDATE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [0:7][31:0] IV_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:7][31:0] IV_224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [0:7][31:0] IV = (MODE == 1) ? IV_224 : IV_256;

    localparam logic [0:63][31:0] K_ROM = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    state_t            state;
    logic [0:7][31:0]  h;
    logic [0:7][31:0]  work;
    logic [0:15][31:0] win;
    logic [5:0]        rnd;
    logic              last;

    logic [0:7][31:0]  work_nxt;
    logic [0:15][31:0] win_nxt;
    logic [31:0]       t1;
    logic [31:0]       t2;
    logic [31:0]       w_new;
    logic [6:0]        rnd_sum;
    logic [0:7][31:0]  h_sum;

    // Unrolled compression rounds for one clock; win[0] always holds W[t] of the round in flight.
    always_comb begin
        work_nxt = work;
        win_nxt  = win;
        t1       = '0;
        t2       = '0;
        w_new    = '0;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            t1 = work_nxt[7] + big_sigma1(work_nxt[4]) + ch(work_nxt[4], work_nxt[5], work_nxt[6])
               + K_ROM[rnd + 6'(r)] + win_nxt[0];
            t2 = big_sigma0(work_nxt[0]) + maj(work_nxt[0], work_nxt[1], work_nxt[2]);
            work_nxt = {t1 + t2, work_nxt[0], work_nxt[1], work_nxt[2],
                        work_nxt[3] + t1, work_nxt[4], work_nxt[5], work_nxt[6]};
            w_new = small_sigma1(win_nxt[14]) + win_nxt[9] + small_sigma0(win_nxt[1]) + win_nxt[0];
            win_nxt = {win_nxt[1:15], w_new};
        end
    end

    // Round counter advance; bit 6 flags that the block's 64 rounds are complete.
    always_comb begin
        rnd_sum = {1'b0, rnd} + 7'(ROUNDS_PER_CYCLE);
    end

    // Chaining value plus working variables, folded in at the end of each block.
    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = h[i] + work[i];
        end
    end

    // Block handshake, round sequencing, chaining update and digest hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            h            <= IV;
            work         <= '0;
            win          <= '0;
            rnd          <= '0;
            last         <= 1'b0;
            blk_ready    <= 1'b1;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid && blk_ready) begin
                        win       <= blk_data;
                        last      <= blk_last;
                        rnd       <= '0;
                        blk_ready <= 1'b0;
                        state     <= ROUND;
                        if (blk_first) begin
                            work <= IV;
                            h    <= IV;
                        end else begin
                            work <= h;
                        end
                    end
                end
                ROUND: begin
                    work <= work_nxt;
                    win  <= win_nxt;
                    rnd  <= rnd_sum[5:0];
                    if (rnd_sum[6]) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    h <= h_sum;
                    if (last) begin
                        digest       <= (MODE == 1) ? {h_sum[0:6], 32'h0} : h_sum;
                        digest_valid <= 1'b1;
                        state        <= HOLD;
                    end else begin
                        blk_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                HOLD: begin
                    if (digest_ready) begin
                        digest_valid <= 1'b0;
                        blk_ready    <= 1'b1;
                        h            <= IV;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_256_stream.sv
// Testbench for sha_256_stream: three instances (SHA-256 R=1, SHA-224 R=2, SHA-256 R=4)
// checked against known digests and a behavioural FIPS 180-4 model.
module tb_sha_256_stream;

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [2047:0] KT = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC_BLK = {"abc", 8'h80, 416'h0, 64'd24};
    localparam logic [511:0] TWO_B1  = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 8'h80, 56'h0};
    localparam logic [511:0] TWO_B2  = {448'h0, 64'd448};

    localparam logic [255:0] ABC256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO256 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] ABC224 =
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

    logic                clk = 1'b0;
    logic [2:0]          rst;
    logic [2:0][511:0]   blk_data;
    logic [2:0]          blk_first;
    logic [2:0]          blk_last;
    logic [2:0]          blk_valid;
    logic [2:0]          blk_ready;
    logic [2:0][255:0]   digest;
    logic [2:0]          digest_valid;
    logic [2:0]          digest_ready;

    int total = 0;
    int bad   = 0;

    logic [255:0] model_h [3];

    sha_256_stream #(.MODE(0), .ROUNDS_PER_CYCLE(1)) dut_r1 (
        .clk(clk), .rst(rst[0]), .blk_data(blk_data[0]), .blk_first(blk_first[0]),
        .blk_last(blk_last[0]), .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]),
        .digest(digest[0]), .digest_valid(digest_valid[0]), .digest_ready(digest_ready[0])
    );

    sha_256_stream #(.MODE(1), .ROUNDS_PER_CYCLE(2)) dut_r2 (
        .clk(clk), .rst(rst[1]), .blk_data(blk_data[1]), .blk_first(blk_first[1]),
        .blk_last(blk_last[1]), .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]),
        .digest(digest[1]), .digest_valid(digest_valid[1]), .digest_ready(digest_ready[1])
    );

    sha_256_stream #(.MODE(0), .ROUNDS_PER_CYCLE(4)) dut_r4 (
        .clk(clk), .rst(rst[2]), .blk_data(blk_data[2]), .blk_first(blk_first[2]),
        .blk_last(blk_last[2]), .blk_valid(blk_valid[2]), .blk_ready(blk_ready[2]),
        .digest(digest[2]), .digest_valid(digest_valid[2]), .digest_ready(digest_ready[2])
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic int rounds_of(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 2 : 4);
    endfunction

    function automatic logic [255:0] iv_of(input int u);
        return (u == 1) ? IV224 : IV256;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook FIPS 180-4 compression with a full 64-entry schedule.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  s [8];
        logic [31:0]  t1, t2;
        logic [255:0] res;
        for (int i = 0; i < 8; i++) s[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[2047 - 32*t -: 32] + w[t];
            t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
            s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + s[i];
        return res;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = $urandom;
        return r;
    endfunction

    // Reference message state: chaining value per instance, IV after reset or a finished message.
    task automatic model_step(input int u, input logic [511:0] d, input bit f, input bit l,
                              output logic [255:0] expd);
        logic [255:0] nh;
        nh = compress(f ? iv_of(u) : model_h[u], d);
        expd = '0;
        if (l) begin
            expd = (u == 1) ? {nh[255:32], 32'h0} : nh;
            model_h[u] = iv_of(u);
        end else begin
            model_h[u] = nh;
        end
    endtask

    task automatic drive_block(input int u, input logic [511:0] d, input bit f, input bit l, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        blk_data[u]  = d;
        blk_first[u] = f;
        blk_last[u]  = l;
        blk_valid[u] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (blk_ready[u]) begin
                @(posedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        blk_valid[u] = 1'b0;
        blk_first[u] = 1'b0;
        blk_last[u]  = 1'b0;
    endtask

    task automatic wait_digest(input int u, output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (digest_valid[u]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_and_collect(input int u, input logic [511:0] d, input bit f, input bit l,
                                    output bit acc, output int lat, output bit seen, output logic [255:0] got);
        drive_block(u, d, f, l, acc);
        lat  = 0;
        seen = 1'b0;
        got  = '0;
        if (acc && l) begin
            wait_digest(u, lat, seen);
            got = digest[u];
        end
    endtask

    task automatic release_digest(input int u);
        digest_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        digest_ready[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            total++;
            if (blk_ready[u] !== 1'b1) begin
                bad++; $display("[TB] FAIL reset_blk_ready u%0d: got %b expected 1", u, blk_ready[u]);
            end
            total++;
            if (digest_valid[u] !== 1'b0) begin
                bad++; $display("[TB] FAIL reset_digest_valid u%0d: got %b expected 0", u, digest_valid[u]);
            end
            total++;
            if (digest[u] !== 256'h0) begin
                bad++; $display("[TB] FAIL reset_digest u%0d: got %h expected 0", u, digest[u]);
            end
            model_h[u] = iv_of(u);
        end
        rst = 3'b111;
    endtask

    task automatic test_abc_sha256();
        logic [255:0] expd, got; bit acc, seen; int lat;
        model_step(0, ABC_BLK, 1'b1, 1'b1, expd);
        send_and_collect(0, ABC_BLK, 1'b1, 1'b1, acc, lat, seen, got);
        total++;
        if (!(acc && seen)) begin
            bad++; $display("[TB] FAIL abc256_handshake: accepted=%b digest_seen=%b expected 1/1", acc, seen);
        end
        total++;
        if (lat !== 65) begin
            bad++; $display("[TB] FAIL abc256_latency: got %0d expected 65", lat);
        end
        total++;
        if (got !== ABC256) begin
            bad++; $display("[TB] FAIL abc256_digest: got %h expected %h", got, ABC256);
        end
        total++;
        if (got !== expd) begin
            bad++; $display("[TB] FAIL abc256_model: got %h expected %h", got, expd);
        end
        release_digest(0);
        @(negedge clk);
        total++;
        if ({digest_valid[0], blk_ready[0]} !== 2'b01) begin
            bad++; $display("[TB] FAIL abc256_release: valid/ready got %b%b expected 01", digest_valid[0], blk_ready[0]);
        end
    endtask

    task automatic test_sha224();
        logic [255:0] expd, got; bit acc, seen; int lat;
        model_step(1, ABC_BLK, 1'b1, 1'b1, expd);
        send_and_collect(1, ABC_BLK, 1'b1, 1'b1, acc, lat, seen, got);
        total++;
        if (!(acc && seen) || lat !== 33) begin
            bad++; $display("[TB] FAIL abc224_latency: got %0d (seen=%b) expected 33", lat, seen);
        end
        total++;
        if (got !== ABC224) begin
            bad++; $display("[TB] FAIL abc224_digest: got %h expected %h", got, ABC224);
        end
        total++;
        if (got !== expd) begin
            bad++; $display("[TB] FAIL abc224_model: got %h expected %h", got, expd);
        end
        release_digest(1);
    endtask

    task automatic test_two_block();
        logic [255:0] expd, got; bit acc, seen; int lat;
        model_step(2, TWO_B1, 1'b1, 1'b0, expd);
        send_and_collect(2, TWO_B1, 1'b1, 1'b0, acc, lat, seen, got);
        total++;
        if (!acc) begin
            bad++; $display("[TB] FAIL two_block_first_accept: accepted=%b expected 1", acc);
        end
        model_step(2, TWO_B2, 1'b0, 1'b1, expd);
        send_and_collect(2, TWO_B2, 1'b0, 1'b1, acc, lat, seen, got);
        total++;
        if (!(acc && seen) || lat !== 17) begin
            bad++; $display("[TB] FAIL two_block_latency: got %0d (seen=%b) expected 17", lat, seen);
        end
        total++;
        if (got !== TWO256) begin
            bad++; $display("[TB] FAIL two_block_digest: got %h expected %h", got, TWO256);
        end
        total++;
        if (got !== expd) begin
            bad++; $display("[TB] FAIL two_block_model: got %h expected %h", got, expd);
        end
        release_digest(2);
    endtask

    task automatic test_backpressure();
        logic [255:0] expd, expd2, got, held; logic [511:0] d1, d2; bit acc, seen; int lat;
        d1 = rand_block();
        d2 = rand_block();
        model_step(2, d1, 1'b1, 1'b1, expd);
        send_and_collect(2, d1, 1'b1, 1'b1, acc, lat, seen, got);
        total++;
        if (!seen || got !== expd) begin
            bad++; $display("[TB] FAIL bp_first_digest: got %h expected %h", got, expd);
        end
        held = got;
        blk_data[2]  = d2;
        blk_first[2] = 1'b1;
        blk_last[2]  = 1'b1;
        blk_valid[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (digest[2] !== held || digest_valid[2] !== 1'b1 || blk_ready[2] !== 1'b0) begin
                bad++; $display("[TB] FAIL bp_hold cycle %0d: digest=%h valid=%b ready=%b expected %h 1 0",
                                i, digest[2], digest_valid[2], blk_ready[2], held);
            end
        end
        digest_ready[2] = 1'b1;
        @(posedge clk);
        #1;
        digest_ready[2] = 1'b0;
        @(negedge clk);
        total++;
        if ({digest_valid[2], blk_ready[2]} !== 2'b01) begin
            bad++; $display("[TB] FAIL bp_release: valid/ready got %b%b expected 01", digest_valid[2], blk_ready[2]);
        end
        @(posedge clk);
        #1;
        blk_valid[2] = 1'b0;
        blk_first[2] = 1'b0;
        blk_last[2]  = 1'b0;
        model_step(2, d2, 1'b1, 1'b1, expd2);
        wait_digest(2, lat, seen);
        total++;
        if (!seen || lat !== 17) begin
            bad++; $display("[TB] FAIL bp_second_latency: got %0d (seen=%b) expected 17", lat, seen);
        end
        total++;
        if (digest[2] !== expd2) begin
            bad++; $display("[TB] FAIL bp_second_digest: got %h expected %h", digest[2], expd2);
        end
        release_digest(2);
    endtask

    task automatic test_reset_abort();
        logic [255:0] expd, got; bit acc, seen, early; int lat;
        drive_block(0, ABC_BLK, 1'b1, 1'b1, acc);
        early = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (digest_valid[0]) early = 1'b1;
        end
        rst[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        model_h[0] = IV256;
        total++;
        if ({blk_ready[0], digest_valid[0]} !== 2'b10 || digest[0] !== 256'h0) begin
            bad++; $display("[TB] FAIL abort_round_state: ready=%b valid=%b digest=%h expected 1 0 0",
                            blk_ready[0], digest_valid[0], digest[0]);
        end
        repeat (80) begin
            @(negedge clk);
            if (digest_valid[0]) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_no_digest: digest_valid seen=%b expected 0", early);
        end
        model_step(0, ABC_BLK, 1'b0, 1'b1, expd);
        send_and_collect(0, ABC_BLK, 1'b0, 1'b1, acc, lat, seen, got);
        total++;
        if (!seen || lat !== 65 || got !== ABC256) begin
            bad++; $display("[TB] FAIL abort_resubmit: lat=%0d digest=%h expected 65 %h", lat, got, ABC256);
        end
        release_digest(0);
        // Reset while a digest is being held
        send_and_collect(2, rand_block(), 1'b1, 1'b1, acc, lat, seen, got);
        rst[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b1;
        model_h[2] = IV256;
        total++;
        if ({blk_ready[2], digest_valid[2]} !== 2'b10 || digest[2] !== 256'h0) begin
            bad++; $display("[TB] FAIL abort_hold_state: ready=%b valid=%b digest=%h expected 1 0 0",
                            blk_ready[2], digest_valid[2], digest[2]);
        end
    endtask

    task automatic test_restart();
        logic [255:0] expd, got; logic [511:0] d; bit acc, seen; int lat;
        d = rand_block();
        model_step(1, d, 1'b1, 1'b0, expd);
        send_and_collect(1, d, 1'b1, 1'b0, acc, lat, seen, got);
        model_step(1, ABC_BLK, 1'b1, 1'b1, expd);
        send_and_collect(1, ABC_BLK, 1'b1, 1'b1, acc, lat, seen, got);
        total++;
        if (!seen || got !== ABC224) begin
            bad++; $display("[TB] FAIL restart_digest: got %h expected %h", got, ABC224);
        end
        release_digest(1);
    endtask

    task automatic test_random_messages();
        logic [255:0] expd, got; logic [511:0] d; bit acc, seen, f, l; int lat, nb;
        for (int it = 0; it < 4; it++) begin
            for (int u = 0; u < 3; u++) begin
                nb = $urandom_range(1, 3);
                for (int b = 0; b < nb; b++) begin
                    d = rand_block();
                    f = (b == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
                    l = (b == nb - 1);
                    model_step(u, d, f, l, expd);
                    send_and_collect(u, d, f, l, acc, lat, seen, got);
                    if (l) begin
                        total++;
                        if (!seen || lat !== 64 / rounds_of(u) + 1) begin
                            bad++; $display("[TB] FAIL rand_latency u%0d it%0d: got %0d expected %0d",
                                            u, it, lat, 64 / rounds_of(u) + 1);
                        end
                        total++;
                        if (got !== expd) begin
                            bad++; $display("[TB] FAIL rand_digest u%0d it%0d: got %h expected %h", u, it, got, expd);
                        end
                        release_digest(u);
                    end else begin
                        total++;
                        if (!acc) begin
                            bad++; $display("[TB] FAIL rand_accept u%0d it%0d: accepted=%b expected 1", u, it, acc);
                        end
                    end
                end
            end
        end
    endtask

    // Test sequence.
    initial begin
        rst          = 3'b000;
        blk_data     = '0;
        blk_first    = '0;
        blk_last     = '0;
        blk_valid    = '0;
        digest_ready = '0;
        $display("[TB] start");
        test_reset();
        test_abc_sha256();
        test_sha224();
        test_two_block();
        test_backpressure();
        test_reset_abort();
        test_restart();
        test_random_messages();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha_256_stream.md
SHA_256_STREAM -- requirements
Module: sha_256_stream

Interface
REQ-001 SHALL have parameter MODE, default 0: 0 = SHA-256, 1 = SHA-224; selects the initial hash values and the digest width.
REQ-002 SHALL have parameter ROUNDS_PER_CYCLE, default 1: compression rounds per clock; legal values 1, 2, 4; any other value is an elaboration error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port blk_data, input, 512 bits: one pre-padded message block, word 0 in bits [511:480].
REQ-006 SHALL have port blk_first, input, 1 bit: when high, the block starts a new message.
REQ-007 SHALL have port blk_last, input, 1 bit: when high, the block ends the message.
REQ-008 SHALL have port blk_valid, input, 1 bit: the source presents a block.
REQ-009 SHALL have port blk_ready, output, 1 bit: the core accepts a block.
REQ-010 SHALL have port digest, output, 256 bits: the message digest.
REQ-011 SHALL have port digest_valid, output, 1 bit: digest is valid.
REQ-012 SHALL have port digest_ready, input, 1 bit: the sink accepts the digest.

Function
REQ-013 A block SHALL be accepted only on a rising edge where blk_valid=1 and blk_ready=1; the input is ignored at all other times.
REQ-014 The state machine SHALL have states IDLE, ROUND, UPDATE and HOLD.
REQ-015 blk_ready SHALL be 1 only in IDLE.
REQ-016 IDLE SHALL go to ROUND on acceptance; the block and its first/last flags are latched, and the working variables a..h are loaded from the chaining value H, or from the IV if blk_first=1.
REQ-017 ROUND SHALL last 64/ROUNDS_PER_CYCLE cycles, performing ROUNDS_PER_CYCLE FIPS 180-4 rounds per cycle.
REQ-018 The message schedule SHALL use a 16-word sliding window; W[t] for t>=16 is computed on the fly.
REQ-019 Round constants K[0..63] SHALL come from an internal ROM.
REQ-020 The round counter SHALL be 6 bits; the state leaves ROUND when the counter would wrap past 63.
REQ-021 UPDATE SHALL take 1 cycle: H[i] <= H[i] + working[i], all additions mod 2^32.
REQ-022 After UPDATE, if the latched last flag is 0, the state SHALL go to IDLE.
REQ-023 After UPDATE, if the latched last flag is 1, the state SHALL go to HOLD with digest_valid=1.
REQ-024 HOLD SHALL keep digest and digest_valid stable until digest_ready=1, then go to IDLE with digest_valid=0 on the next edge.
REQ-025 On leaving HOLD, H SHALL be reloaded with the IV.
REQ-026 Latency SHALL be: acceptance edge N -> digest_valid first high after edge N + 64/ROUNDS_PER_CYCLE + 1, i.e. 65, 33 or 17 cycles.
REQ-027 In MODE=0 the IV SHALL be 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, and digest = H0..H7.
REQ-028 In MODE=1 the IV SHALL be c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4, digest[255:32] = H0..H6, and digest[31:0] = 0.
REQ-029 A block with blk_first=1 and blk_last=1 SHALL be hashed as a complete single-block message.
REQ-030 blk_first=1 arriving mid-message SHALL discard the chaining value and restart from the IV.
REQ-031 A non-first block right after reset or after a completed digest SHALL chain from the IV.
REQ-032 digest SHALL hold its last value outside HOLD; it is meaningful only while digest_valid=1.

Reset
REQ-033 When rst=0 at a rising edge, the state SHALL become IDLE, H becomes the IV, the round counter becomes 0, blk_ready becomes 1, digest_valid becomes 0 and digest becomes 0.
REQ-034 A reset asserted in ROUND, UPDATE or HOLD SHALL abort the operation with no digest output, and the next accepted block starts from the IV.
REQ-035 No output SHALL change asynchronously to clk.

Verification
REQ-036 MODE=0, R=1, one block for padded "abc", first=last=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with digest_valid first high 65 cycles after acceptance.
REQ-037 MODE=0, R=4, two-block padded "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first on block 1, last on block 2) -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, with digest_valid 17 cycles after the second acceptance.
REQ-038 MODE=1, R=2, "abc" -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
REQ-039 Backpressure: digest_ready held 0 for 10 cycles -> digest stable and blk_ready=0 throughout, while a blk_valid presented during that time is not accepted until one cycle after digest_ready=1.
REQ-040 rst=0 for one cycle in the middle of ROUND of the "abc" block, then "abc" resubmitted -> no digest_valid before the resubmission, and the correct "abc" digest after it.
REQ-041 A first-only block followed by a first=last=1 block of "abc" -> the "abc" digest, showing the restart discards the earlier chaining value.
